// File: rtl/io_port_responder.sv
// Memory-mapped I/O slave for the CPU io_* bus. It holds the LED and ready
// registers, captures debounced switch input with a valid/ack handshake, and
// scans a 32-bit word onto an 8-digit hex display.
module io_port_responder #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SCAN_DIV        = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  io_addr,
   input  logic [31:0] io_dout,
   input  logic        io_we,
   output logic [31:0] io_din,
   input  logic        valid,
   input  logic [4:0]  in,
   output logic [4:0]  out0,
   output logic        ready,
   output logic [2:0]  an,
   output logic [3:0]  seg
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] SC_LAST = SW'(SCAN_DIV - 1);

   localparam logic [7:0] A_OUT0  = 8'h00;
   localparam logic [7:0] A_READY = 8'h04;
   localparam logic [7:0] A_OUT1  = 8'h08;
   localparam logic [7:0] A_STAT  = 8'h10;
   localparam logic [7:0] A_DATA  = 8'h14;

   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
   } io_req_t;

   io_req_t          req;
   logic [1:0]       valid_sync;
   logic [1:0][4:0]  in_sync;
   logic             db_level;
   logic [DW-1:0]    db_cnt;
   logic [SW-1:0]    scan_cnt;
   logic [31:0]      out1;
   logic [4:0]       in_data;
   logic             in_vld;
   logic             overrun;
   logic             db_diff;
   logic             db_flip;
   logic             rise;
   logic             ack;

   assign req     = '{we: io_we, addr: io_addr, data: io_dout};
   assign db_diff = valid_sync[1] ^ db_level;
   assign db_flip = db_diff && (db_cnt == DB_LAST);
   // a flip while the synced level is 1 can only be a 0->1 transition
   assign rise    = db_flip && valid_sync[1];
   assign ack     = req.we && (req.addr == A_STAT);

   // two-flop synchronizers for the asynchronous switch inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_sync <= '0;
         in_sync    <= '0;
      end else begin
         valid_sync <= {valid_sync[0], valid};
         in_sync    <= {in_sync[0], in};
      end
   end

   // debounce: level follows sync only after DEBOUNCE_CYCLES consecutive differing cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         db_level <= 1'b0;
         db_cnt   <= '0;
      end else if (db_flip) begin
         db_level <= valid_sync[1];
         db_cnt   <= '0;
      end else if (db_diff) begin
         db_cnt   <= db_cnt + 1'b1;
      end else begin
         db_cnt   <= '0;
      end
   end

   // capture on debounced rise; a simultaneous ack loses to the capture but clears overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         in_data <= '0;
         in_vld  <= 1'b0;
         overrun <= 1'b0;
      end else if (rise) begin
         in_data <= in_sync[1];
         in_vld  <= 1'b1;
         overrun <= ack ? 1'b0 : (overrun | in_vld);
      end else if (ack) begin
         in_vld  <= 1'b0;
         overrun <= 1'b0;
      end
   end

   // CPU-writable output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         out0  <= '0;
         ready <= 1'b0;
         out1  <= '0;
      end else if (req.we) begin
         case (req.addr)
            A_OUT0:  out0  <= req.data[4:0];
            A_READY: ready <= req.data[0];
            A_OUT1:  out1  <= req.data;
            default: ;
         endcase
      end
   end

   // display scan: advance digit every SCAN_DIV cycles, an wraps naturally at 8
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         an       <= '0;
      end else if (scan_cnt == SC_LAST) begin
         scan_cnt <= '0;
         an       <= an + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign seg = out1[{an, 2'b00} +: 4];

   // read mux, combinational from address and current registers
   always_comb begin
      io_din = '0;
      case (req.addr)
         A_OUT0:  io_din = {27'b0, out0};
         A_READY: io_din = {31'b0, ready};
         A_OUT1:  io_din = out1;
         A_STAT:  io_din = {30'b0, overrun, in_vld};
         A_DATA:  io_din = {27'b0, in_data};
         default: io_din = '0;
      endcase
   end

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: register table, debounce/handshake sequences,
// display scan sequence and a randomized run against a behavioural model.
module tb_io_port_responder;

   localparam int DEB = 4;
   localparam int SD  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  io_addr;
   logic [31:0] io_dout;
   logic        io_we;
   logic [31:0] io_din;
   logic        valid;
   logic [4:0]  in;
   logic [4:0]  out0;
   logic        ready;
   logic [2:0]  an;
   logic [3:0]  seg;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   io_port_responder #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
      .io_din(io_din), .valid(valid), .in(in), .out0(out0), .ready(ready),
      .an(an), .seg(seg)
   );

   // behavioural model state
   logic [4:0]  m_out0;
   logic        m_ready;
   logic [31:0] m_out1;
   logic [4:0]  m_data;
   logic        m_vld;
   logic        m_ovr;
   logic        m_lvl;
   logic        dv [2];
   logic [4:0]  di [2];
   logic        win [$];
   int          cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [7:0] a);
      case (a)
         8'h00:   return {27'b0, m_out0};
         8'h04:   return {31'b0, m_ready};
         8'h08:   return m_out1;
         8'h10:   return {30'b0, m_ovr, m_vld};
         8'h14:   return {27'b0, m_data};
         default: return 32'h0;
      endcase
   endfunction

   // model a rising edge with the inputs currently applied
   task automatic model_edge();
      logic       sv;
      logic [4:0] si;
      logic       chg;
      logic       ack;
      if (rst) begin
         m_out0 = '0; m_ready = 0; m_out1 = '0; m_data = '0;
         m_vld = 0; m_ovr = 0; m_lvl = 0;
         dv[0] = 0; dv[1] = 0; di[0] = '0; di[1] = '0;
         win.delete();
         cyc = 0;
      end else begin
         sv = dv[1];
         si = di[1];
         // level flips once the last DEB synced samples all disagree with it
         win.push_back(sv);
         if (win.size() > DEB) void'(win.pop_front());
         chg = 0;
         if (win.size() == DEB) begin
            chg = 1;
            foreach (win[i]) if (win[i] == m_lvl) chg = 0;
         end
         ack = io_we && (io_addr == 8'h10);
         if (chg) m_lvl = sv;
         if (chg && sv) begin
            m_ovr  = ack ? 1'b0 : (m_ovr | m_vld);
            m_vld  = 1;
            m_data = si;
         end else if (ack) begin
            m_vld = 0;
            m_ovr = 0;
         end
         if (io_we) begin
            if (io_addr == 8'h00) m_out0  = io_dout[4:0];
            if (io_addr == 8'h04) m_ready = io_dout[0];
            if (io_addr == 8'h08) m_out1  = io_dout;
         end
         dv[1] = dv[0]; dv[0] = valid;
         di[1] = di[0]; di[0] = in;
         cyc++;
      end
   endtask

   // one clock: update model at the edge, compare all outputs 1ns later
   task automatic step();
      int d;
      @(posedge clk);
      model_edge();
      #1;
      d = (cyc / SD) % 8;
      chk("m_out0", {27'b0, out0}, {27'b0, m_out0});
      chk("m_ready", {31'b0, ready}, {31'b0, m_ready});
      chk("m_an", {29'b0, an}, d);
      chk("m_seg", {28'b0, seg}, (m_out1 >> (4 * d)) & 32'hF);
      chk("m_din", io_din, m_read(io_addr));
   endtask

   task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
      io_we   = 0;
      io_addr = a;
      #1;
      chk(name, io_din, exp);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // count edges until in_vld rises; 21 means it never did
   task automatic wait_vld(output int n);
      io_we   = 0;
      io_addr = 8'h10;
      n = 21;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (io_din[0] === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  waddr;
      logic [31:0] wdata;
      logic [7:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   initial begin
      vec_t        tbl [12];
      int          n;
      logic [31:0] word;
      int          d;

      rst = 1; io_we = 0; io_addr = 0; io_dout = 0; valid = 0; in = 0;
      step();
      step();
      rst = 0;
      chk("rst_an", {29'b0, an}, 32'h0);
      chk("rst_seg", {28'b0, seg}, 32'h0);

      tbl[0]  = '{0, 8'h00, 32'h0,        8'h00, 32'h0};
      tbl[1]  = '{0, 8'h00, 32'h0,        8'h04, 32'h0};
      tbl[2]  = '{0, 8'h00, 32'h0,        8'h08, 32'h0};
      tbl[3]  = '{0, 8'h00, 32'h0,        8'h10, 32'h0};
      tbl[4]  = '{0, 8'h00, 32'h0,        8'h14, 32'h0};
      tbl[5]  = '{0, 8'h00, 32'h0,        8'h3C, 32'h0};
      tbl[6]  = '{1, 8'h00, 32'hFFFFFFF5, 8'h00, 32'h15};
      tbl[7]  = '{1, 8'h04, 32'h00000001, 8'h04, 32'h1};
      tbl[8]  = '{1, 8'h20, 32'hFFFFFFFF, 8'h20, 32'h0};
      tbl[9]  = '{0, 8'h00, 32'h0,        8'h00, 32'h15};
      tbl[10] = '{1, 8'h08, 32'h89ABCDEF, 8'h08, 32'h89ABCDEF};
      tbl[11] = '{1, 8'h04, 32'hFFFFFFFE, 8'h04, 32'h0};
      foreach (tbl[i]) begin
         io_we = tbl[i].we; io_addr = tbl[i].waddr; io_dout = tbl[i].wdata;
         step();
         rd($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].exp);
      end
      chk("out0_pin", {27'b0, out0}, 32'h15);

      // debounce capture latency
      rst = 1; step(); rst = 0;
      in = 5'h13; valid = 1;
      wait_vld(n);
      chk("cap_latency", n, DEB + 2);
      rd("cap_data", 8'h14, 32'h13);
      rd("cap_stat", 8'h10, 32'h1);

      // ack, then a short glitch is rejected
      valid = 0; steps(8);
      io_we = 1; io_addr = 8'h10; step(); io_we = 0;
      valid = 1; steps(3); valid = 0; steps(10);
      rd("glitch_stat", 8'h10, 32'h0);

      // overrun: second capture before ack
      in = 5'h13; valid = 1; steps(8);
      valid = 0; steps(8);
      in = 5'h07; valid = 1; steps(8);
      rd("ovr_stat", 8'h10, 32'h3);
      rd("ovr_data", 8'h14, 32'h07);
      valid = 0; steps(8);
      io_we = 1; io_addr = 8'h10; step(); io_we = 0;
      rd("ack_stat", 8'h10, 32'h0);

      // capture coincident with ack
      in = 5'h11; valid = 1; steps(8);
      valid = 0; steps(8);
      in = 5'h0A; valid = 1;
      steps(DEB + 1);
      io_we = 1; io_addr = 8'h10; step(); io_we = 0;
      rd("coinc_stat", 8'h10, 32'h1);
      rd("coinc_data", 8'h14, 32'h0A);
      valid = 0; steps(8);

      // display scan from a fresh reset
      rst = 1; step(); rst = 0;
      word = 32'h89ABCDEF;
      io_we = 1; io_addr = 8'h08; io_dout = word; step(); io_we = 0;
      for (int k = 1; k <= 17; k++) begin
         d = (k / 2) % 8;
         chk($sformatf("scan_an%0d", k), {29'b0, an}, d);
         chk($sformatf("scan_seg%0d", k), {28'b0, seg}, (word >> (4 * d)) & 32'hF);
         step();
      end

      // reset mid-debounce with valid held high
      valid = 1; in = 5'h05; steps(3);
      rst = 1; step(); rst = 0;
      wait_vld(n);
      chk("rst_requal", n, DEB + 2);
      rd("rst_requal_data", 8'h14, 32'h05);

      // randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 5) == 0) valid = ~valid;
         in = 5'($urandom);
         io_we = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 7))
            0: io_addr = 8'h00;
            1: io_addr = 8'h04;
            2: io_addr = 8'h08;
            3: io_addr = 8'h10;
            4: io_addr = 8'h14;
            5: io_addr = 8'h10;
            6: io_addr = 8'h3C;
            default: io_addr = 8'($urandom);
         endcase
         io_dout = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
